// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and types for the write-back arbiter
package wb_arbiter_pkg;

    localparam int N_REQ  = 10;
    localparam int N_PORT = 2;
    localparam int IDX_W  = $clog2(N_REQ);

    // Requester slots
    localparam int REQ_ALU1 = 0;
    localparam int REQ_ALU2 = 1;
    localparam int REQ_ALU3 = 2;
    localparam int REQ_JUMP = 3;
    localparam int REQ_MEM1 = 4;
    localparam int REQ_MEM2 = 5;
    localparam int REQ_MUL1 = 6;
    localparam int REQ_MUL2 = 7;
    localparam int REQ_DIV1 = 8;
    localparam int REQ_DIV2 = 9;

    typedef logic [4:0]       reg_addr_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    // Successor of a requester index in the circular scan order
    function automatic req_idx_t rr_next(input req_idx_t idx);
        return (idx == req_idx_t'(N_REQ - 1)) ? '0 : idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - requester handshake and register-file write port bundle
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    reg_addr_t [N_REQ-1:0]   req_addr;
    logic [N_REQ-1:0][31:0]  req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_PORT-1:0]       wt_en;
    reg_addr_t [N_PORT-1:0]  wt_addr;
    logic [N_PORT-1:0][31:0] wt_data;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wt_en, wt_addr, wt_data
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wt_en, wt_addr, wt_data
    );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// rtl/wb_arbiter_rr_pick.sv - rotate-and-find-first-set picking two distinct-register winners
module rr_pick
    import wb_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0]      cand,
    input  reg_addr_t [N_REQ-1:0] addr,
    input  req_idx_t              ptr,
    output logic                  g0_vld,
    output req_idx_t              g0_idx,
    output logic                  g1_vld,
    output req_idx_t              g1_idx
);

    logic [N_REQ-1:0] mask2;

    // First set bit of mask walking ptr, ptr+1, ... with wrap-around
    function automatic void first_set(
        input  logic [N_REQ-1:0] mask,
        input  req_idx_t         start,
        output logic             found,
        output req_idx_t         idx
    );
        int j;
        found = 1'b0;
        idx   = start;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(start) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && mask[j]) begin
                found = 1'b1;
                idx   = req_idx_t'(j);
            end
        end
    endfunction

    // Second pick reuses the same scan with port 0's register masked out, which also removes port 0's winner
    always_comb begin
        mask2 = '0;
        first_set(cand, ptr, g0_vld, g0_idx);
        for (int i = 0; i < N_REQ; i++) begin
            mask2[i] = cand[i] && (addr[i] != addr[g0_idx]);
        end
        first_set(mask2, ptr, g1_vld, g1_idx);
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter onto two register-file write ports
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    wb_arbiter_if.slave  bus,
    output logic [15:0]  stall_cnt
);

    req_idx_t         ptr;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] zero_req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] refused;
    logic             g0_vld;
    logic             g1_vld;
    req_idx_t         g0_idx;
    req_idx_t         g1_idx;
    logic             active;

    assign active = rst && !flush;

    // Split valid requests into those needing a port and x0 writes that are simply acknowledged
    always_comb begin
        cand     = '0;
        zero_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand[i]     = bus.req_valid[i] && (bus.req_addr[i] != '0);
            zero_req[i] = bus.req_valid[i] && (bus.req_addr[i] == '0);
        end
    end

    rr_pick u_rr_pick (
        .cand   (cand),
        .addr   (bus.req_addr),
        .ptr    (ptr),
        .g0_vld (g0_vld),
        .g0_idx (g0_idx),
        .g1_vld (g1_vld),
        .g1_idx (g1_idx)
    );

    // Ready depends only on requests and ptr, never on the registered write ports
    always_comb begin
        grant = '0;
        if (g0_vld) begin
            grant[g0_idx] = 1'b1;
        end
        if (g1_vld) begin
            grant[g1_idx] = 1'b1;
        end
        bus.req_ready = active ? (grant | zero_req) : '0;
        refused       = bus.req_valid & ~bus.req_ready;
    end

    // Register winners onto the write ports and rotate past the last nonzero grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr         <= '0;
            bus.wt_en   <= '0;
            bus.wt_addr <= '0;
            bus.wt_data <= '0;
        end else begin
            bus.wt_en <= '0;
            if (!flush) begin
                if (g0_vld) begin
                    bus.wt_en[0]   <= 1'b1;
                    bus.wt_addr[0] <= bus.req_addr[g0_idx];
                    bus.wt_data[0] <= bus.req_data[g0_idx];
                end
                if (g1_vld) begin
                    bus.wt_en[1]   <= 1'b1;
                    bus.wt_addr[1] <= bus.req_addr[g1_idx];
                    bus.wt_data[1] <= bus.req_data[g1_idx];
                end
                if (g1_vld) begin
                    ptr <= rr_next(g1_idx);
                end else if (g0_vld) begin
                    ptr <= rr_next(g0_idx);
                end
            end
        end
    end

    // Saturating count of cycles where at least one valid request was turned away
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!flush && (|refused) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a behavioural model
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] stall_cnt;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester stimulus
    bit          v [N_REQ];
    logic [4:0]  a [N_REQ];
    logic [31:0] d [N_REQ];

    // Reference model state
    int          m_ptr;
    bit          m_en   [N_PORT];
    logic [4:0]  m_addr [N_PORT];
    logic [31:0] m_data [N_PORT];
    int          m_stall;
    int          gnt [N_PORT];
    int          n_gnt;
    logic [N_REQ-1:0] exp_ready;
    logic [N_REQ-1:0] obs_ready;
    bit          seen5;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_valid[i] = v[i];
            bus.req_addr[i]  = a[i];
            bus.req_data[i]  = d[i];
        end
    endtask

    function automatic void model_pick();
        int i;
        exp_ready = '0;
        n_gnt     = 0;
        if (rst === 1'b1 && flush === 1'b0) begin
            for (int k = 0; k < N_REQ; k++) begin
                i = (m_ptr + k) % N_REQ;
                if (v[i]) begin
                    if (a[i] == 5'd0) begin
                        exp_ready[i] = 1'b1;
                    end else if (n_gnt == 0) begin
                        gnt[0] = i; n_gnt = 1; exp_ready[i] = 1'b1;
                    end else if (n_gnt == 1 && a[i] != a[gnt[0]]) begin
                        gnt[1] = i; n_gnt = 2; exp_ready[i] = 1'b1;
                    end
                end
            end
        end
    endfunction

    function automatic void model_update();
        bit any_refused;
        if (rst !== 1'b1) begin
            m_ptr = 0;
            m_stall = 0;
            for (int p = 0; p < N_PORT; p++) begin
                m_en[p] = 0; m_addr[p] = '0; m_data[p] = '0;
            end
        end else begin
            for (int p = 0; p < N_PORT; p++) m_en[p] = 0;
            if (flush === 1'b0) begin
                for (int p = 0; p < n_gnt; p++) begin
                    m_en[p]   = 1;
                    m_addr[p] = a[gnt[p]];
                    m_data[p] = d[gnt[p]];
                end
                if (n_gnt > 0) m_ptr = (gnt[n_gnt-1] + 1) % N_REQ;
                any_refused = 0;
                for (int i = 0; i < N_REQ; i++) begin
                    if (v[i] && !exp_ready[i]) any_refused = 1;
                end
                if (any_refused && m_stall < 65535) m_stall++;
            end
        end
    endfunction

    // Called at a falling edge; returns at the next falling edge
    task automatic run_cycle();
        drive();
        #1;
        model_pick();
        obs_ready = bus.req_ready;
        check_eq("req_ready", obs_ready, exp_ready);
        if (obs_ready[5]) seen5 = 1;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_eq("wt_en", bus.wt_en, {m_en[1], m_en[0]});
        check_eq("wt_addr", bus.wt_addr, {m_addr[1], m_addr[0]});
        check_eq("wt_data", bus.wt_data, {m_data[1], m_data[0]});
        check_eq("stall_cnt", stall_cnt, m_stall);
        if (&bus.wt_en) check_eq("wt_distinct", bus.wt_addr[0] == bus.wt_addr[1], 1'b0);
    endtask

    task automatic retire_clear();
        for (int i = 0; i < N_REQ; i++) if (exp_ready[i]) v[i] = 0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = 0; a[i] = '0; d[i] = '0;
        end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        clear_all();
        exp_ready = '0;
        seen5 = 0;
        drive();
        @(negedge clk);

        // Reset then idle
        run_cycle();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check_eq("idle_wt_en", bus.wt_en, 2'b00);
        check_eq("idle_stall", stall_cnt, 16'd0);

        // Basic arbitration from ptr = 0
        v[0] = 1; a[0] = 5'd5; d[0] = 32'h11;
        v[4] = 1; a[4] = 5'd6; d[4] = 32'h22;
        v[9] = 1; a[9] = 5'd7; d[9] = 32'h33;
        run_cycle();
        check_eq("arb_c0_en", bus.wt_en, 2'b11);
        check_eq("arb_c0_p0", {bus.wt_addr[0], bus.wt_data[0]}, {5'd5, 32'h11});
        check_eq("arb_c0_p1", {bus.wt_addr[1], bus.wt_data[1]}, {5'd6, 32'h22});
        retire_clear();
        run_cycle();
        check_eq("arb_c1_en", bus.wt_en, 2'b01);
        check_eq("arb_c1_p0", {bus.wt_addr[0], bus.wt_data[0]}, {5'd7, 32'h33});
        check_eq("arb_stall", stall_cnt, 16'd1);
        retire_clear();

        // Same-register conflict
        v[1] = 1; a[1] = 5'd8; d[1] = 32'h101;
        v[2] = 1; a[2] = 5'd8; d[2] = 32'h202;
        v[3] = 1; a[3] = 5'd9; d[3] = 32'h303;
        run_cycle();
        check_eq("conf_c0_en", bus.wt_en, 2'b11);
        check_eq("conf_c0_addr", bus.wt_addr, {5'd9, 5'd8});
        check_eq("conf_c0_data0", bus.wt_data[0], 32'h101);
        retire_clear();
        run_cycle();
        check_eq("conf_c1_en", bus.wt_en, 2'b01);
        check_eq("conf_c1_p0", {bus.wt_addr[0], bus.wt_data[0]}, {5'd8, 32'h202});
        retire_clear();

        // Zero-address drop
        v[6] = 1; a[6] = 5'd0; d[6] = 32'h666;
        v[0] = 1; a[0] = 5'd3; d[0] = 32'h100;
        v[1] = 1; a[1] = 5'd4; d[1] = 32'h111;
        run_cycle();
        check_eq("zero_ready6", obs_ready[6], 1'b1);
        check_eq("zero_en", bus.wt_en, 2'b11);
        check_eq("zero_data", bus.wt_data, {32'h111, 32'h100});
        retire_clear();

        // Flush with everybody requesting
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = 1; a[i] = 5'(i + 11); d[i] = 32'h3400 + i;
        end
        flush = 1'b1;
        repeat (3) begin
            run_cycle();
            check_eq("flush_ready", obs_ready, '0);
            check_eq("flush_en", bus.wt_en, 2'b00);
            check_eq("flush_stall", stall_cnt, 16'd2);
        end
        flush = 1'b0;
        run_cycle();
        check_eq("flush_resume", bus.wt_addr, {5'd14, 5'd13});
        clear_all();

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!v[i] || exp_ready[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    a[i] = 5'($urandom_range(0, 7));
                    d[i] = $urandom;
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 199) != 0);
            run_cycle();
        end
        flush = 1'b0;

        // Saturation with requester 5 starved, then a mid-operation reset
        rst = 1'b0;
        clear_all();
        run_cycle();
        rst = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = 1;
            a[i] = (i >= 3 && i <= 5) ? 5'd4 : 5'(i + 1);
            d[i] = $urandom;
        end
        seen5 = 0;
        for (int c = 0; c < 65540; c++) begin
            run_cycle();
            for (int i = 0; i < N_REQ; i++) if (exp_ready[i]) d[i] = $urandom;
        end
        check_eq("sat_stall", stall_cnt, 16'hFFFF);
        check_eq("sat_starved5", seen5, 1'b0);
        rst = 1'b0;
        run_cycle();
        check_eq("rst_mid_en", bus.wt_en, 2'b00);
        check_eq("rst_mid_stall", stall_cnt, 16'd0);
        rst = 1'b1;
        clear_all();
        run_cycle();
        check_eq("rst_post_en", bus.wt_en, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter N_REQ, default 10, number of write-back requesters: index 0-2 ALU1-3, 3 JUMP, 4-5 MEM1-2, 6-7 MUL1-2, 8-9 DIV1-2.
REQ-002 Parameter N_PORT, fixed 2, number of register-file write ports driven.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  pipeline flush.
REQ-006 req_valid  input  N_REQ  per-requester write-back request.
REQ-007 req_addr  input  N_REQ x 5  destination register per requester.
REQ-008 req_data  input  N_REQ x 32  result data per requester.
REQ-009 req_ready  output  N_REQ  per-requester grant, combinational.
REQ-010 wt_en  output  N_PORT  port write enable, registered.
REQ-011 wt_addr  output  N_PORT x 5  port destination register, registered.
REQ-012 wt_data  output  N_PORT x 32  port write data, registered.
REQ-013 stall_cnt  output  16  saturating count of cycles in which a valid request was refused.

Function
REQ-014 A transfer occurs on a rising edge where req_valid[i] and req_ready[i] are both 1; a requester SHALL hold valid, addr and data stable until its transfer.
REQ-015 A round-robin pointer ptr (0..N_REQ-1) SHALL set the scan order ptr, ptr+1, ..., wrapping modulo N_REQ.
REQ-016 Each cycle, scanning in that order, the block SHALL grant up to N_PORT valid requests with req_addr != 0, assigning them to port 0 and then port 1.
REQ-017 A valid request with req_addr == 0 SHALL get req_ready = 1 in the same cycle, use no port and cause no write.
REQ-018 If the second candidate has the same req_addr as the port-0 grant, it SHALL be skipped and the scan SHALL continue; only one write per register per cycle.
REQ-019 Write-back latency SHALL be one cycle: on the edge after a port grant, wt_en[p] = 1 and wt_addr[p]/wt_data[p] hold the granted values; an unused port SHALL get wt_en[p] = 0 and hold its previous addr and data.
REQ-020 After any nonzero-address grant, ptr SHALL move to (index of last such grant + 1) mod N_REQ; with no such grant, ptr SHALL hold; zero-address grants SHALL not move ptr.
REQ-021 While flush = 1: every req_ready SHALL be 0, the next-edge wt_en SHALL be 0, ptr SHALL hold, and stall_cnt SHALL not increment.
REQ-022 When flush = 0, stall_cnt SHALL increment by 1 on each edge where some req_valid[i] = 1 and req_ready[i] = 0, and SHALL saturate at 16'hFFFF.
REQ-023 Both outputs are consumed by a register file that writes on the falling edge, so registered port outputs SHALL be stable from each rising edge onward; wt_addr[0] != wt_addr[1] SHALL hold whenever both wt_en bits are 1.
REQ-024 The block SHALL have no combinational path from wt_* to req_ready.

Reset
REQ-025 While rst = 0 at a rising edge, the block SHALL set ptr = 0, wt_en = 0, wt_addr = 0, wt_data = 0 and stall_cnt = 0.
REQ-026 While rst = 0, req_ready SHALL be all 0.
REQ-027 A reset asserted in the middle of operation SHALL discard any pending registered write, so no wt_en pulse appears on the edge after reset is released.

Structure
REQ-028 A shared package SHALL hold the requester index constants (ALU1..DIV2), N_REQ, N_PORT and the 5-bit register-address typedef.
REQ-029 The round-robin rotate-and-find-first-set SHALL be one sub-module, rr_pick, instantiated once and called twice with a mask for the second pick.

Verification
REQ-030 Reset then idle: rst = 0 for 2 cycles, then rst = 1 with no valid requests -> wt_en = 0, stall_cnt = 0, ptr = 0.
REQ-031 Arbitration: valid on 0 (x5 = 0x11), 4 (x6 = 0x22) and 9 (x7 = 0x33) with ptr = 0 -> cycle 0 grants 0 and 4, port0 = (5, 0x11), port1 = (6, 0x22), ptr = 5; cycle 1 grants 9, port0 = (7, 0x33), ptr = 0; stall_cnt = 1.
REQ-032 Same-register conflict: requesters 1 and 2 both target x8, requester 3 targets x9 -> cycle 0 grants 1 and 3; cycle 1 grants 2; never both wt_addr = 8.
REQ-033 Zero-address drop: requester 6 valid with addr 0 plus requesters 0 and 1 valid -> req_ready[6] = 1 in the same cycle, no port carries requester 6's data, and ports carry requesters 0 and 1.
REQ-034 Flush: all 10 requesters valid and flush = 1 for 3 cycles -> req_ready = 0, wt_en = 0, stall_cnt and ptr unchanged; after flush = 0, grants resume from the held ptr.
REQ-035 Saturation and reset mid-operation: requester 5 valid with ready never given to it, counter preloaded to 0xFFFE via long stall -> stall_cnt stays at 0xFFFF; a one-cycle rst = 0 pulse on a cycle with 2 grants -> no wt_en pulse after release and stall_cnt = 0.
